// File: rtl/warp_pkg.sv
// Shared constants, entry layout and helpers for the warp instruction queue.
package warp_pkg;

    localparam int unsigned INST_W       = 32;
    localparam int unsigned PC_W_DEFAULT = 64;

    // Storage word layout, MSB first: {pc, compressed, inst}
    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic                    compressed;
        logic [INST_W-1:0]       inst;
    } warp_entry_t;

    // Saturate a lane count to the number of physical lanes
    function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned lim);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/warp_queue_ram.sv
// DEPTH-entry register array: IN_W write ports and OUT_W read ports,
// each addressed relative to a base pointer that wraps modulo DEPTH.
module warp_queue_ram #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IN_W    = 2,
    parameter int unsigned OUT_W   = 2,
    parameter int unsigned ENTRY_W = 97
) (
    input  logic                       clk_i,
    input  logic [IN_W-1:0]            wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_base_i,
    input  logic [IN_W*ENTRY_W-1:0]    wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_base_i,
    output logic [OUT_W*ENTRY_W-1:0]   rd_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_addr [IN_W];
    logic [PTR_W-1:0]   rd_addr [OUT_W];

    // Rotated addresses; PTR_W-bit adds wrap naturally since DEPTH is a power of two
    always_comb begin
        for (int unsigned k = 0; k < IN_W; k++) begin
            wr_addr[k] = wr_base_i + PTR_W'(k);
        end
        for (int unsigned j = 0; j < OUT_W; j++) begin
            rd_addr[j] = rd_base_i + PTR_W'(j);
        end
    end

    // Write enabled lanes into consecutive entries
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < IN_W; k++) begin
            if (wr_en_i[k]) begin
                mem_q[wr_addr[k]] <= wr_data_i[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Combinational read of the OUT_W entries starting at the read base
    always_comb begin
        rd_data_o = '0;
        for (int unsigned j = 0; j < OUT_W; j++) begin
            rd_data_o[j*ENTRY_W +: ENTRY_W] = mem_q[rd_addr[j]];
        end
    end

endmodule

// File: rtl/warp_inst_queue.sv
// Instruction queue between fetch and decode: multi-lane push, multi-lane
// pop, branch flush, registered ready and a sticky protocol-error flag.
module warp_inst_queue
    import warp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned PC_W  = PC_W_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [$clog2(IN_W+1)-1:0]    i_count,
    input  logic [IN_W*INST_W-1:0]       i_inst,
    input  logic [IN_W-1:0]              i_compressed,
    input  logic [IN_W*PC_W-1:0]         i_pc,
    output logic [OUT_W-1:0]             o_valid,
    output logic [OUT_W*INST_W-1:0]      o_inst,
    output logic [OUT_W-1:0]             o_compressed,
    output logic [OUT_W*PC_W-1:0]        o_pc,
    input  logic [$clog2(OUT_W+1)-1:0]   i_take,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_err
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = $clog2(DEPTH+1);
    localparam int unsigned CNT_W   = $clog2(IN_W+1);
    localparam int unsigned TAKE_W  = $clog2(OUT_W+1);
    localparam int unsigned ENTRY_W = PC_W + 1 + INST_W;

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     ready_q, ready_d;
    logic                     err_q, err_d;

    logic                     push_fire;
    logic [CNT_W-1:0]         push_cnt;
    logic [TAKE_W-1:0]        pop_cnt;
    logic [IN_W-1:0]          wr_en;
    logic [IN_W*ENTRY_W-1:0]  wr_data;
    logic [OUT_W*ENTRY_W-1:0] rd_data;

    // Push/pop amounts, error detection and next pointer/level/ready state
    always_comb begin
        push_fire = i_valid && ready_q;
        push_cnt  = '0;
        if (push_fire) begin
            push_cnt = CNT_W'(clamp_count(32'(i_count), IN_W));
        end
        pop_cnt = (32'(i_take) > 32'(level_q)) ? TAKE_W'(level_q) : i_take;

        err_d = err_q
              | (push_fire && (32'(i_count) > IN_W))
              | (32'(i_take) > 32'(level_q));

        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
            ready_d = 1'b1;
        end else begin
            head_d  = head_q + PTR_W'(pop_cnt);
            tail_d  = tail_q + PTR_W'(push_cnt);
            level_d = level_q + LVL_W'(push_cnt) - LVL_W'(pop_cnt);
            ready_d = (DEPTH - 32'(level_d)) >= IN_W;
        end
    end

    // Queue control state with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Pack fetch lanes into storage words; a flush suppresses the write
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int unsigned k = 0; k < IN_W; k++) begin
            wr_en[k] = !i_flush && (32'(push_cnt) > k);
            wr_data[k*ENTRY_W +: ENTRY_W] =
                {i_pc[k*PC_W +: PC_W], i_compressed[k], i_inst[k*INST_W +: INST_W]};
        end
    end

    warp_queue_ram #(
        .DEPTH   (DEPTH),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk_i     (i_clk),
        .wr_en_i   (wr_en),
        .wr_base_i (tail_q),
        .wr_data_i (wr_data),
        .rd_base_i (head_q),
        .rd_data_o (rd_data)
    );

    // Present head entries; lanes beyond the occupancy read as zero
    always_comb begin
        o_valid      = '0;
        o_inst       = '0;
        o_compressed = '0;
        o_pc         = '0;
        for (int unsigned j = 0; j < OUT_W; j++) begin
            o_valid[j] = 32'(level_q) > j;
            if (o_valid[j]) begin
                o_inst[j*INST_W +: INST_W] = rd_data[j*ENTRY_W +: INST_W];
                o_compressed[j]            = rd_data[j*ENTRY_W + INST_W];
                o_pc[j*PC_W +: PC_W]       = rd_data[j*ENTRY_W + INST_W + 1 +: PC_W];
            end
        end
    end

    assign o_ready = ready_q;
    assign o_level = level_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_warp_inst_queue.sv
// Self-checking bench for warp_inst_queue against a queue-based reference model.
module tb_warp_inst_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IN_W  = 2;
    localparam int unsigned OUT_W = 2;
    localparam int unsigned PC_W  = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000_0000_0000;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_flush = 1'b0;
    logic         i_valid = 1'b0;
    logic [1:0]   i_count = '0;
    logic [63:0]  i_inst = '0;
    logic [1:0]   i_compressed = '0;
    logic [127:0] i_pc = '0;
    logic [1:0]   i_take = '0;
    logic         o_ready;
    logic [1:0]   o_valid;
    logic [63:0]  o_inst;
    logic [1:0]   o_compressed;
    logic [127:0] o_pc;
    logic [3:0]   o_level;
    logic         o_err;

    warp_inst_queue #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .PC_W  (PC_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_count      (i_count),
        .i_inst       (i_inst),
        .i_compressed (i_compressed),
        .i_pc         (i_pc),
        .o_valid      (o_valid),
        .o_inst       (o_inst),
        .o_compressed (o_compressed),
        .o_pc         (o_pc),
        .i_take       (i_take),
        .o_level      (o_level),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] inst;
        logic        c;
        logic [63:0] pc;
    } ent_t;

    ent_t mq[$];
    logic m_ready = 1'b1;
    logic m_err   = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    // Reference: apply one clock edge using the queue rules directly
    function automatic void model_step();
        int unsigned n_push;
        int unsigned n_pop;
        n_push = 0;
        if (i_valid && m_ready) begin
            if (i_count > 2) m_err = 1'b1;
            n_push = (i_count > 2) ? 2 : int'(i_count);
        end
        if (int'(i_take) > mq.size()) m_err = 1'b1;
        if (i_flush) begin
            mq.delete();
            m_ready = 1'b1;
            return;
        end
        n_pop = (int'(i_take) > mq.size()) ? mq.size() : int'(i_take);
        repeat (n_pop) void'(mq.pop_front());
        for (int k = 0; k < int'(n_push); k++) begin
            mq.push_back('{i_inst[k*32 +: 32], i_compressed[k], i_pc[k*64 +: 64]});
        end
        m_ready = (DEPTH - mq.size()) >= IN_W;
    endfunction

    function automatic void model_outputs(output logic [1:0] v, output logic [63:0] ins,
                                          output logic [1:0] c, output logic [127:0] pc);
        v = '0; ins = '0; c = '0; pc = '0;
        for (int j = 0; j < 2; j++) begin
            if (j < mq.size()) begin
                v[j]            = 1'b1;
                ins[j*32 +: 32] = mq[j].inst;
                c[j]            = mq[j].c;
                pc[j*64 +: 64]  = mq[j].pc;
            end
        end
    endfunction

    task automatic idle();
        i_flush = 1'b0; i_valid = 1'b0; i_count = '0; i_take = '0;
        i_inst = '0; i_compressed = '0; i_pc = '0;
    endtask

    task automatic cycle(input logic fl, input logic v, input logic [1:0] cnt,
                         input logic [63:0] ins, input logic [1:0] c,
                         input logic [127:0] pc, input logic [1:0] tk);
        i_flush = fl; i_valid = v; i_count = cnt; i_inst = ins;
        i_compressed = c; i_pc = pc; i_take = tk;
        @(posedge i_clk);
        model_step();
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        i_rst_n = 1'b0;
        mq.delete(); m_ready = 1'b1; m_err = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        i_rst_n = 1'b0;
        mq.delete(); m_ready = 1'b1; m_err = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_valid, o_level, o_ready, o_err} !== {2'b00, 4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_ctrl: got v=%b lvl=%0d rdy=%b err=%b, want v=00 lvl=0 rdy=1 err=0",
                     o_valid, o_level, o_ready, o_err);
        end
        n_cmp++;
        if ({o_inst, o_compressed, o_pc} !== 194'd0) begin
            n_bad++;
            $display("FAIL reset_data: got inst=%h c=%b pc=%h, want all zero", o_inst, o_compressed, o_pc);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic_push();
        do_reset();
        cycle(0, 1, 2, {32'h0010_0093, 32'h0000_0013}, 2'b00, {BASE + 64'd4, BASE}, 0);
        n_cmp++;
        if ({o_valid, o_level} !== {2'b11, 4'd2}) begin
            n_bad++;
            $display("FAIL basic_ctrl: got v=%b lvl=%0d, want v=11 lvl=2", o_valid, o_level);
        end
        n_cmp++;
        if ({o_inst, o_pc} !== {32'h0010_0093, 32'h0000_0013, BASE + 64'd4, BASE}) begin
            n_bad++;
            $display("FAIL basic_data: got inst=%h pc=%h, want inst=0010009300000013 pc=%h%h",
                     o_inst, o_pc, BASE + 64'd4, BASE);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            cycle(0, 1, 2, {$urandom, $urandom}, 2'b00, {BASE + 64'(16*n+4), BASE + 64'(16*n)}, 0);
            n_cmp++;
            if ({o_level, o_ready} !== {4'(2*n), (n < 4) ? 1'b1 : 1'b0}) begin
                n_bad++;
                $display("FAIL fill_%0d: got lvl=%0d rdy=%b, want lvl=%0d rdy=%b",
                         n, o_level, o_ready, 2*n, (n < 4));
            end
        end
        // Full queue ignores fetch, including an out-of-range count
        cycle(0, 1, 3, {$urandom, $urandom}, 2'b11, '1, 0);
        n_cmp++;
        if ({o_valid, o_level, o_ready, o_err} !== {2'b11, 4'd8, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL fill_ignore: got v=%b lvl=%0d rdy=%b err=%b, want v=11 lvl=8 rdy=0 err=0",
                     o_valid, o_level, o_ready, o_err);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] np;
        do_reset();
        cycle(0, 1, 2, {$urandom, $urandom}, 2'b00, {BASE + 64'd4, BASE}, 0);
        np = BASE + 64'd8;
        for (int n = 1; n <= 12; n++) begin
            cycle(0, 1, 2, {$urandom, $urandom}, 2'b00, {np + 64'd4, np}, 2);
            np = np + 64'd8;
            n_cmp++;
            if ({o_level, o_err, o_pc} !== {4'd2, 1'b0, BASE + 64'(8*n+4), BASE + 64'(8*n)}) begin
                n_bad++;
                $display("FAIL wrap_%0d: got lvl=%0d err=%b pc=%h, want lvl=2 err=0 pc=%h%h",
                         n, o_level, o_err, o_pc, BASE + 64'(8*n+4), BASE + 64'(8*n));
            end
        end
    endtask

    task automatic test_partial();
        do_reset();
        cycle(0, 1, 2, {32'h11, 32'h10}, 2'b00, {BASE + 64'h8, BASE + 64'h4}, 0);
        cycle(0, 1, 1, {32'h0, 32'h12}, 2'b00, {64'h0, BASE + 64'hC}, 0);
        cycle(0, 1, 1, {32'h0, 32'h4501}, 2'b01, {64'h0, BASE + 64'h20}, 1);
        n_cmp++;
        if ({o_level, o_compressed, o_inst} !== {4'd3, 2'b00, 32'h12, 32'h11}) begin
            n_bad++;
            $display("FAIL partial_lvl: got lvl=%0d c=%b inst=%h, want lvl=3 c=00 inst=0000001200000011",
                     o_level, o_compressed, o_inst);
        end
        cycle(0, 0, 0, '0, 2'b00, '0, 1);
        n_cmp++;
        if ({o_level, o_compressed, o_pc[127:64], o_inst[63:32]} !== {4'd2, 2'b10, BASE + 64'h20, 32'h4501}) begin
            n_bad++;
            $display("FAIL partial_rvc: got lvl=%0d c=%b pc1=%h inst1=%h, want lvl=2 c=10 pc1=%h inst1=00004501",
                     o_level, o_compressed, o_pc[127:64], o_inst[63:32], BASE + 64'h20);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(0, 1, 2, {$urandom, $urandom}, 2'b00, {$urandom, $urandom, $urandom, $urandom}, 0);
        cycle(0, 1, 2, {$urandom, $urandom}, 2'b00, {$urandom, $urandom, $urandom, $urandom}, 0);
        cycle(0, 1, 1, {$urandom, $urandom}, 2'b00, {$urandom, $urandom, $urandom, $urandom}, 0);
        cycle(1, 1, 2, {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 2'b11, '1, 2);
        n_cmp++;
        if ({o_valid, o_level, o_ready, o_inst} !== {2'b00, 4'd0, 1'b1, 64'd0}) begin
            n_bad++;
            $display("FAIL flush_state: got v=%b lvl=%0d rdy=%b inst=%h, want v=00 lvl=0 rdy=1 inst=0",
                     o_valid, o_level, o_ready, o_inst);
        end
        cycle(0, 1, 1, {32'h0, 32'h0000_AAAA}, 2'b00, {64'h0, BASE + 64'h40}, 0);
        n_cmp++;
        if ({o_valid, o_level, o_inst, o_pc[63:0]} !== {2'b01, 4'd1, 32'h0, 32'h0000_AAAA, BASE + 64'h40}) begin
            n_bad++;
            $display("FAIL flush_after: got v=%b lvl=%0d inst=%h pc0=%h, want v=01 lvl=1 inst=000000000000aaaa pc0=%h",
                     o_valid, o_level, o_inst, o_pc[63:0], BASE + 64'h40);
        end
    endtask

    task automatic test_err();
        do_reset();
        cycle(0, 1, 1, {32'h0, 32'h55}, 2'b00, {64'h0, BASE}, 0);
        cycle(0, 0, 0, '0, 2'b00, '0, 2);
        n_cmp++;
        if ({o_valid, o_level, o_err} !== {2'b00, 4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL err_overtake: got v=%b lvl=%0d err=%b, want v=00 lvl=0 err=1", o_valid, o_level, o_err);
        end
        cycle(1, 0, 0, '0, 2'b00, '0, 0);
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky_flush: got err=%b, want 1", o_err);
        end
        // Take on an empty queue
        do_reset();
        cycle(0, 0, 0, '0, 2'b00, '0, 1);
        n_cmp++;
        if ({o_level, o_err} !== {4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL err_empty_take: got lvl=%0d err=%b, want lvl=0 err=1", o_level, o_err);
        end
        // Out-of-range fetch count is clamped and flagged
        do_reset();
        cycle(0, 1, 3, {32'h22, 32'h21}, 2'b00, {BASE + 64'h4, BASE}, 0);
        n_cmp++;
        if ({o_level, o_err, o_inst} !== {4'd2, 1'b1, 32'h22, 32'h21}) begin
            n_bad++;
            $display("FAIL err_count: got lvl=%0d err=%b inst=%h, want lvl=2 err=1 inst=0000002200000021",
                     o_level, o_err, o_inst);
        end
        // Asynchronous reset between clock edges
        #2;
        i_rst_n = 1'b0;
        mq.delete(); m_ready = 1'b1; m_err = 1'b0;
        #1;
        n_cmp++;
        if ({o_valid, o_level, o_ready, o_err, o_inst} !== {2'b00, 4'd0, 1'b1, 1'b0, 64'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b lvl=%0d rdy=%b err=%b inst=%h, want v=00 lvl=0 rdy=1 err=0 inst=0",
                     o_valid, o_level, o_ready, o_err, o_inst);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0]   ev, ec, cnt, tk;
        logic [63:0]  ei;
        logic [127:0] ep;
        logic         fl;
        int unsigned  lim;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            fl  = ($urandom_range(0, 19) == 0);
            cnt = 2'($urandom_range(0, 2));
            lim = (mq.size() < 2) ? mq.size() : 2;
            tk  = 2'($urandom_range(0, lim));
            if (n >= 250 && !fl && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) cnt = 2'd3;
                else tk = 2'($urandom_range(lim + 1, 3));
            end
            cycle(fl, 1'($urandom_range(0, 1)), cnt, {$urandom, $urandom}, 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, tk);
            model_outputs(ev, ei, ec, ep);
            n_cmp++;
            if ({o_valid, o_level, o_ready, o_err} !== {ev, 4'(mq.size()), m_ready, m_err}) begin
                n_bad++;
                $display("FAIL rand_ctrl[%0d]: got v=%b lvl=%0d rdy=%b err=%b, want v=%b lvl=%0d rdy=%b err=%b",
                         n, o_valid, o_level, o_ready, o_err, ev, mq.size(), m_ready, m_err);
            end
            n_cmp++;
            if ({o_inst, o_compressed, o_pc} !== {ei, ec, ep}) begin
                n_bad++;
                $display("FAIL rand_data[%0d]: got inst=%h c=%b pc=%h, want inst=%h c=%b pc=%h",
                         n, o_inst, o_compressed, o_pc, ei, ec, ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_fill();
        test_wrap();
        test_partial();
        test_flush();
        test_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/warp_inst_queue.md
Name: warp_inst_queue

Overview:
- Parametrised instruction queue between warp_fetch and the decode lanes; replaces the fixed two-wide IF/ID register barrier.
- Accepts 0..IN_W instructions per cycle from fetch and presents the oldest OUT_W entries to decode, which consumes 0..OUT_W per cycle.
- A branch redirect flushes the queue. Per-entry PC and compressed flag travel with each instruction.

Parameters:
- DEPTH, 8: number of entries. Must be a power of two and ≥ IN_W+OUT_W.
- IN_W, 2: fetch lanes written per cycle.
- OUT_W, 2: decode lanes presented per cycle.
- PC_W, 64: PC width per entry.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  branch redirect; discard all contents
- i_valid  in  1  fetch bundle present
- o_ready  out  1  queue can accept a full IN_W bundle
- i_count  in  $clog2(IN_W+1)  number of valid fetch lanes, lane 0 first
- i_inst  in  IN_W*32  fetch instructions, lane k at [k*32 +: 32]
- i_compressed  in  IN_W  per-lane RVC flag
- i_pc  in  IN_W*PC_W  per-lane PC
- o_valid  out  OUT_W  thermometer mask of valid output lanes
- o_inst  out  OUT_W*32  head entries, oldest in lane 0
- o_compressed  out  OUT_W  per-lane RVC flag
- o_pc  out  OUT_W*PC_W  per-lane PC
- i_take  in  $clog2(OUT_W+1)  entries consumed by decode this cycle
- o_level  out  $clog2(DEPTH+1)  current occupancy
- o_err  out  1  sticky protocol-error flag

Behaviour:
- **Reset.** Head and tail pointers = 0, level = 0, o_valid = 0, o_ready = 1, o_err = 0. All data outputs read 0.
- **Storage.** Circular buffer. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Push.** Occurs when i_valid && o_ready.
  - Lane k < i_count is written to entry (tail+k) mod DEPTH; tail advances by i_count.
  - i_count = 0 is a legal no-op.
  - When o_ready = 0, all inputs are ignored.
- **o_ready.** Registered: o_ready <= (DEPTH − level_next) ≥ IN_W. There is no same-cycle forwarding from a pop to ready.
- **Output presentation.**
  - Output lane j shows entry (head+j) mod DEPTH.
  - o_valid[j] = (j < level). Lanes with o_valid[j] = 0 drive o_inst/o_compressed/o_pc = 0.
  - The read path is combinational from registered state, so an entry pushed in cycle N is first visible in cycle N+1. There is no input-to-output bypass.
- **Pop.**
  - pop = min(i_take, level). Head advances by pop.
  - If i_take > level, o_err is set at the next edge and only `level` entries are popped.
- **Level update.** level_next = level + push_count − pop. Push and pop in the same cycle are both honoured; each uses the pre-update state.
- **Illegal i_count.** i_count > IN_W with i_valid && o_ready sets o_err. The push is clamped to IN_W.
- **Flush.** Synchronous and highest priority.
  - Next cycle: head = tail = 0, level = 0, o_valid = 0, o_ready = 1.
  - A same-cycle push and take are discarded.
  - o_err is not cleared.
- **o_err.** Sticky; cleared only by reset.
- **Reset mid-operation.** Async reset forces the reset values immediately, regardless of the clock.
- **Full boundary.** At level = DEPTH, o_ready = 0 and o_valid is all ones.
- **Empty boundary.** At level = 0, o_valid = 0 and any i_take > 0 raises o_err.

Decomposition:
- warp_pkg holds:
  - INST_W = 32
  - default PC_W
  - the entry struct/packing order {pc, compressed, inst}
  - a popcount/clamp helper function
- One natural sub-module: warp_queue_ram, the DEPTH-entry register array with IN_W write ports and OUT_W read ports, addressed by the rotated pointers.
- Pointer, level, ready and error logic stay in warp_inst_queue.

Test Plan (DEPTH=8, IN_W=2, OUT_W=2):
- **Basic push.**
  - Stimulus: after reset, one push with i_count=2, inst {0x00000013, 0x00100093}, pc {0x8000000000000000, 0x8000000000000004}, i_take=0.
  - Required next cycle: o_valid=2'b11, lane0 = 0x00000013 / 0x8000000000000000, level=2.
- **Fill to full.**
  - Stimulus: push count=2 on four consecutive cycles, take=0.
  - Required: level reaches 8 and o_ready=0 the cycle after the 4th push. A fifth i_valid is ignored and level stays 8.
- **Wrap-around.**
  - Stimulus: push 2 and take 2 every cycle for 12 cycles, PCs incrementing by 4.
  - Required: level constant 2, output PCs strictly sequential across the pointer wrap, o_err=0.
- **Partial and compressed.**
  - Stimulus: at level 3, push count=1 with compressed=1 and pc 0x8000000000000020, take=1.
  - Required: level=3; the new entry appears with o_compressed=1 once it reaches lane 0 or 1.
- **Flush priority.**
  - Stimulus: at level 5, i_flush=1 with i_valid=1/count=2 and take=2.
  - Required next cycle: level=0, o_valid=0, o_ready=1; the pushed instructions never appear.
- **Protocol error.**
  - Stimulus: at level 1, i_take=2.
  - Required: exactly one entry popped, level=0, o_err=1. o_err stays 1 through a later flush and clears only on i_rst_n low.
